// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: bus types, register numbers, exception codes and
// Status/Cause field positions.
package cp0_reg_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned INT_W  = 6;

    typedef logic [REG_W-1:0]  reg_bus_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_bus_t ZERO_WORD = 32'h0000_0000;

    localparam reg_addr_t CP0_REG_COUNT   = 5'd9;
    localparam reg_addr_t CP0_REG_COMPARE = 5'd11;
    localparam reg_addr_t CP0_REG_STATUS  = 5'd12;
    localparam reg_addr_t CP0_REG_CAUSE   = 5'd13;
    localparam reg_addr_t CP0_REG_EPC     = 5'd14;
    localparam reg_addr_t CP0_REG_PRID    = 5'd15;
    localparam reg_addr_t CP0_REG_CONFIG  = 5'd16;

    localparam reg_bus_t EXC_INTERRUPT = 32'h0000_0001;
    localparam reg_bus_t EXC_RI        = 32'h0000_000a;
    localparam reg_bus_t EXC_ERET      = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT = 5'h00;
    localparam logic [4:0] EXCCODE_RI  = 5'h0a;

    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // Software-writable Cause bits: IV(23), WP(22), IP1..0(9:8)
    localparam reg_bus_t CAUSE_WMASK = 32'h00C0_0300;

    // Architectural state that changes at run time
    typedef struct packed {
        reg_bus_t count;
        reg_bus_t compare;
        reg_bus_t status;
        reg_bus_t cause;
        reg_bus_t epc;
    } cp0_state_t;

    function automatic logic [4:0] exc_code(input reg_bus_t excepttype);
        return (excepttype == EXC_RI) ? EXCCODE_RI : EXCCODE_INT;
    endfunction

endpackage

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer, Status/Cause/EPC exception state,
// read-only PrId/Config, and a combinational mfc0 read port.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter reg_bus_t PRID_VALUE   = 32'h004c_0102,
    parameter reg_bus_t CONFIG_RESET = 32'h0000_8000,
    parameter reg_bus_t STATUS_RESET = 32'h1000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [REG_W-1:0]    data_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [REG_W-1:0]    data_o,
    input  logic [INT_W-1:0]    int_i,
    input  logic [REG_W-1:0]    excepttype_i,
    input  logic [REG_W-1:0]    current_inst_addr_i,
    input  logic                is_in_delayslot_i,
    output logic [REG_W-1:0]    count_o,
    output logic [REG_W-1:0]    compare_o,
    output logic [REG_W-1:0]    status_o,
    output logic [REG_W-1:0]    cause_o,
    output logic [REG_W-1:0]    epc_o,
    output logic [REG_W-1:0]    config_o,
    output logic [REG_W-1:0]    prid_o,
    output logic                timer_int_o
);

    cp0_state_t cur;
    cp0_state_t nxt;
    logic       timer_nxt;

    // Next state: free-running effects, then mtc0, then exception on top
    always_comb begin
        nxt       = cur;
        timer_nxt = timer_int_o;

        nxt.count = cur.count + 32'd1;
        if ((cur.compare != ZERO_WORD) && (cur.count == cur.compare)) begin
            timer_nxt = 1'b1;
        end
        nxt.cause[CAUSE_IP_HI:CAUSE_IP_LO] = int_i;

        if (we_i) begin
            case (waddr_i)
                CP0_REG_COUNT:   nxt.count = data_i;
                CP0_REG_COMPARE: begin
                    nxt.compare = data_i;
                    timer_nxt   = 1'b0;
                end
                CP0_REG_STATUS:  nxt.status = data_i;
                CP0_REG_CAUSE:   nxt.cause  = (nxt.cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
                CP0_REG_EPC:     nxt.epc    = data_i;
                default: ;
            endcase
        end

        // EXL is taken after the older mtc0 has been applied
        case (excepttype_i)
            EXC_INTERRUPT, EXC_RI: begin
                if (!nxt.status[STATUS_EXL]) begin
                    nxt.epc = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                : current_inst_addr_i;
                    nxt.cause[CAUSE_BD]    = is_in_delayslot_i;
                    nxt.status[STATUS_EXL] = 1'b1;
                end
                nxt.cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code(excepttype_i);
            end
            EXC_ERET: nxt.status[STATUS_EXL] = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur.count   <= ZERO_WORD;
            cur.compare <= ZERO_WORD;
            cur.status  <= STATUS_RESET;
            cur.cause   <= ZERO_WORD;
            cur.epc     <= ZERO_WORD;
            timer_int_o <= 1'b0;
        end else begin
            cur         <= nxt;
            timer_int_o <= timer_nxt;
        end
    end

    assign count_o   = cur.count;
    assign compare_o = cur.compare;
    assign status_o  = cur.status;
    assign cause_o   = cur.cause;
    assign epc_o     = cur.epc;
    // Read-only registers hold their fixed values
    assign config_o  = CONFIG_RESET;
    assign prid_o    = PRID_VALUE;

    // mfc0 read port; no forwarding of the write in flight
    always_comb begin
        data_o = ZERO_WORD;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = cur.count;
            CP0_REG_COMPARE: data_o = cur.compare;
            CP0_REG_STATUS:  data_o = cur.status;
            CP0_REG_CAUSE:   data_o = cur.cause;
            CP0_REG_EPC:     data_o = cur.epc;
            CP0_REG_PRID:    data_o = PRID_VALUE;
            CP0_REG_CONFIG:  data_o = CONFIG_RESET;
            default:         data_o = ZERO_WORD;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg with hand-computed expected values.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_reg dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .data_o              (data_o),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
        we_i    = 1'b1;
        waddr_i = addr;
        data_i  = val;
        step();
        we_i    = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        raddr_i = addr;
        #1;
        check(tag, data_o, exp);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_count"},   count_o,   32'h0);
        check({pfx, "_compare"}, compare_o, 32'h0);
        check({pfx, "_status"},  status_o,  32'h1000_0000);
        check({pfx, "_cause"},   cause_o,   32'h0);
        check({pfx, "_epc"},     epc_o,     32'h0);
        check({pfx, "_config"},  config_o,  32'h0000_8000);
        check({pfx, "_prid"},    prid_o,    32'h004c_0102);
        check({pfx, "_timer"},   {31'b0, timer_int_o}, 32'h0);
    endtask

    task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds);
        excepttype_i        = code;
        current_inst_addr_i = pc;
        is_in_delayslot_i   = ds;
        step();
        excepttype_i        = 32'h0;
        is_in_delayslot_i   = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0;
        int_i = '0; excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("rst0");

        // Cause write mask and interrupt sampling
        int_i = 6'b101010;
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_wr", cause_o, 32'h00C0_AB00);
        read_chk("rd_cause", 5'd13, 32'h00C0_AB00);
        read_chk("rd_prid", 5'd15, 32'h004c_0102);
        read_chk("rd_unlisted", 5'd3, 32'h0);
        int_i = 6'b000000;
        check("cause_ip_latency", cause_o, 32'h00C0_AB00);
        step();
        check("cause_ip_clear", cause_o, 32'h00C0_0300);

        // Read-only registers
        mtc0(5'd15, 32'h0);
        mtc0(5'd16, 32'h0);
        check("prid_ro", prid_o, 32'h004c_0102);
        check("config_ro", config_o, 32'h0000_8000);
        read_chk("rd_config", 5'd16, 32'h0000_8000);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFE);
        check("count_load", count_o, 32'hFFFF_FFFE);
        step();
        check("count_max", count_o, 32'hFFFF_FFFF);
        step();
        check("count_wrap", count_o, 32'h0);

        // Timer interrupt
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd15);
        check("timer_count15", count_o, 32'd15);
        check("timer_idle", {31'b0, timer_int_o}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (count_o == 32'd20) found = 1'b1;
            else step();
        end
        check("timer_wait", {31'b0, found}, 32'h1);
        check("timer_at_match", {31'b0, timer_int_o}, 32'h0);
        step();
        check("timer_set", {31'b0, timer_int_o}, 32'h1);
        step();
        check("timer_sticky", {31'b0, timer_int_o}, 32'h1);
        mtc0(5'd11, 32'd100);
        check("timer_clr", {31'b0, timer_int_o}, 32'h0);
        check("compare_100", compare_o, 32'd100);

        // Asynchronous reset mid-run at count 37
        mtc0(5'd9, 32'd30);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (count_o == 32'd37) found = 1'b1;
            else step();
        end
        check("count37_wait", {31'b0, found}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_async");
        step();
        rst = 1'b0;

        // First exception: RI in delay slot
        exc(32'ha, 32'h8000_0120, 1'b1);
        check("ri_epc", epc_o, 32'h8000_011C);
        check("ri_cause", cause_o, 32'h8000_0028);
        check("ri_status", status_o, 32'h1000_0002);

        // Nested exceptions keep EPC and BD
        exc(32'ha, 32'h8000_0200, 1'b0);
        check("nest_ri_epc", epc_o, 32'h8000_011C);
        check("nest_ri_cause", cause_o, 32'h8000_0028);
        exc(32'h1, 32'h8000_0300, 1'b0);
        check("nest_int_epc", epc_o, 32'h8000_011C);
        check("nest_int_cause", cause_o, 32'h8000_0000);

        // Unknown code: no change
        exc(32'h8, 32'h8000_0400, 1'b1);
        check("unk_status", status_o, 32'h1000_0002);
        check("unk_cause", cause_o, 32'h8000_0000);
        check("unk_epc", epc_o, 32'h8000_011C);

        // eret clears EXL only
        exc(32'he, 32'h8000_0500, 1'b0);
        check("eret_status", status_o, 32'h1000_0000);
        check("eret_epc", epc_o, 32'h8000_011C);

        // mtc0 EPC and interrupt in the same cycle
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0000_1234;
        exc(32'h1, 32'h8000_0040, 1'b0);
        we_i = 1'b0;
        check("same_epc", epc_o, 32'h8000_0040);
        check("same_cause", cause_o, 32'h0);
        check("same_status", status_o, 32'h1000_0002);
        read_chk("rd_epc", 5'd14, 32'h8000_0040);

        // Full Status write
        mtc0(5'd12, 32'h0000_ff01);
        read_chk("rd_status", 5'd12, 32'h0000_ff01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the MIPS core.
- Holds Count, Compare, Status, Cause, EPC, PrId and Config.
- Commits architectural exception state when the MEM stage reports an exception.
- Drives epc_o/status_o/cause_o back to the MEM-stage exception logic, which produces excepttype_i and cp0_epc_i for the pipeline controller.
- Sits upstream of the controller. It is the sole source of the EPC value used on eret and of the timer interrupt.

Parameters:
- PRID_VALUE, 32'h004c0102, reset/constant value of PrId.
- CONFIG_RESET, 32'h00008000, reset value of Config (BE=1).
- STATUS_RESET, 32'h10000000, reset value of Status (CU0=1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- we_i  in  1  mtc0 write enable (from WB)
- waddr_i  in  5  CP0 register number written
- data_i  in  32  write data
- raddr_i  in  5  CP0 register number read (mfc0)
- data_o  out  32  combinational read data
- int_i  in  6  external hardware interrupt lines (IP7..IP2)
- excepttype_i  in  32  committed exception code from MEM: 0x1 interrupt, 0xa reserved instruction, 0xe eret, 0 none
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  registered register values
- timer_int_o  out  1  timer interrupt request

Behaviour:
- Reset: count_o=0, compare_o=0, status_o=STATUS_RESET, cause_o=0, epc_o=0, config_o=CONFIG_RESET, prid_o=PRID_VALUE, timer_int_o=0.
  - Reset is asynchronous and takes effect mid-operation without waiting for a clock.
- Register numbers: Count=9, Compare=11, Status=12, Cause=13, EPC=14, PrId=15, Config=16.
- Count:
  - Increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
  - An mtc0 to Count in the same cycle loads data_i instead of incrementing.
- Timer:
  - When compare_o != 0 and count_o == compare_o, timer_int_o <= 1 on the next edge.
  - timer_int_o is sticky until an mtc0 to Compare, which loads Compare and clears timer_int_o in the same edge.
- Cause[15:10] <= int_i every cycle, so interrupt lines are sampled with 1-cycle latency.
- mtc0 writes:
  - Status and EPC are written in full.
  - Cause writes only bits 9:8 (IP1..0), 23 (IV) and 22 (WP); other Cause bits are untouched.
  - PrId and Config are read-only; writes to them are ignored.
  - Writes to unlisted numbers are ignored.
- Exception commit (excepttype_i != 0):
  - 0x1 or 0xa with Status.EXL=0:
    - EPC <= current_inst_addr_i - 4 if is_in_delayslot_i, else current_inst_addr_i.
    - Cause.BD(31) <= is_in_delayslot_i.
    - Status.EXL(1) <= 1.
    - Cause.ExcCode(6:2) <= 5'h00 for 0x1, 5'h0a for 0xa.
  - 0x1 or 0xa with Status.EXL=1: only ExcCode is updated; EPC and BD are preserved (nested exception).
  - 0xe: Status.EXL <= 0; nothing else changes.
  - Any other nonzero code: no state change.
- Simultaneous mtc0 and exception in one cycle:
  - The mtc0 (older instruction, in WB) is applied first.
  - Exception updates then override any overlapping fields.
- Read:
  - data_o is a combinational mux on raddr_i over the current registered values.
  - Unlisted numbers read 32'h0.
  - Forwarding of in-flight writes is not done here.
- Latency: every write and exception effect is visible on outputs the cycle after the edge.

Decomposition:
- Shared include file holds:
  - RegBus, ZeroWord.
  - CP0 register-number constants (CP0_REG_COUNT etc.).
  - Exception-type codes (EXC_INTERRUPT=32'h1, EXC_RI=32'ha, EXC_ERET=32'he).
  - Status/Cause bit-index constants.
- No sub-module: a single flat always block for state plus a combinational read mux.

Test Plan:
- Reset mid-run with count_o=37 → all outputs return to reset values immediately, with no clock edge.
- mtc0 Compare=20, Count=15 → timer_int_o=1 one cycle after count_o==20; mtc0 Compare=100 → timer_int_o=0 next cycle and Compare=100.
- excepttype_i=0xa, PC=0x80000120, delayslot=1, EXL=0 → epc_o=0x8000011C, cause_o[31]=1, cause_o[6:2]=0x0a, status_o[1]=1.
- Same exception repeated with EXL=1 and PC=0x80000200 → epc_o remains 0x8000011C, ExcCode=0x0a; then excepttype_i=0xe → status_o[1]=0.
- Same cycle: mtc0 EPC=0x1234 and excepttype_i=0x1, PC=0x80000040, EXL=0 → epc_o=0x80000040, cause_o[6:2]=0.
- mtc0 Cause=32'hFFFFFFFF with int_i=6'b101010 → cause_o=32'h00C0AB00 (IV, WP, IP[9:8] and IP7..2 set; all other bits 0); mfc0 raddr_i=15 → data_o=0x004c0102; raddr_i=3 → data_o=0.
